mem_arbiter: RTL and testbench

- Sequences and shares the single-port main RAM between two requesters: instruction fetch (read-only) and data access (load/store).
- Sits between the control/datapath and the RAM. Drives the RAM's CS/WE/ADDR/DataIn, waits on its ready flag, and returns read data through per-port request/valid handshakes.
- Two-way round-robin arbitration, a programmable write hold time, and a read timeout.

---
 rtl/lc3_mem_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types for the main-RAM arbiter: FSM state encoding and requester IDs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Requester IDs double as bit positions in the request/grant vectors.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant plus the updated priority pointer.
// Latency: purely combinational, grant in the same cycle as the request.
// Backpressure: none; the caller decides when a grant is taken via upd_en_i.
module rr_arbiter2
  import lc3_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       upd_en_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  // Single requester wins outright; on contention the pointer picks the winner.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[PORT_FETCH] && req_i[PORT_DATA]) begin
      gnt_o[ptr_i] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end

  // After a grant the pointer names the port that was not served.
  always_comb begin
    ptr_o = ptr_i;
    if (upd_en_i && (gnt_o != 2'b00)) begin
      ptr_o = gnt_o[PORT_DATA] ? PORT_FETCH : PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port main RAM between instruction fetch and data load/store.
// Latency: read 3 cycles with ready RAM, write WRITE_CYCLES+1, timed-out read TIMEOUT+1.
// Backpressure: requesters hold REQ until their VALID pulse; RAM stalls reads via MEM_READY.
module mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int WRITE_CYCLES = 1,
  parameter int TIMEOUT      = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              F_REQ,
  input  logic [ADDR_W-1:0] F_ADDR,
  output logic              F_VALID,
  output logic [DATA_W-1:0] F_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_VALID,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              ERR,
  output logic              BUSY,
  output logic              MEM_CS,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DIN,
  input  logic [DATA_W-1:0] MEM_DOUT,
  input  logic              MEM_READY
);

  localparam int RD_CNT_W = $clog2(TIMEOUT + 1);
  localparam int WR_CNT_W = $clog2(WRITE_CYCLES + 1);
  localparam logic [RD_CNT_W-1:0] RD_ONE = RD_CNT_W'(1);
  localparam logic [RD_CNT_W-1:0] RD_MIN = RD_CNT_W'(2);
  localparam logic [RD_CNT_W-1:0] RD_MAX = RD_CNT_W'(TIMEOUT);
  localparam logic [WR_CNT_W-1:0] WR_ONE = WR_CNT_W'(1);
  localparam logic [WR_CNT_W-1:0] WR_MAX = WR_CNT_W'(WRITE_CYCLES);

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                port_q, port_d;
  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic                mem_cs_q, mem_cs_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                f_vld_q, f_vld_d;
  logic                d_vld_q, d_vld_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [1:0]          gnt;
  logic                arb_ptr;
  logic                gnt_any;
  logic                gnt_data;
  logic                gnt_we;
  logic                rd_ok;
  logic                rd_to;
  logic                wr_end;

  rr_arbiter2 u_arb (
    .req_i    ({D_REQ, F_REQ}),
    .ptr_i    (ptr_q),
    .upd_en_i (state_q == IDLE),
    .gnt_o    (gnt),
    .ptr_o    (arb_ptr)
  );

  // Requests are only honoured in IDLE; the grant fixes port and direction.
  assign gnt_any  = (state_q == IDLE) && (gnt != 2'b00);
  assign gnt_data = gnt[PORT_DATA];
  assign gnt_we   = gnt_data && D_WE;

  // The first READ cycle ignores MEM_READY since it may still reflect the previous read.
  assign rd_ok  = (state_q == READ) && (rd_cnt_q >= RD_MIN) && MEM_READY;
  assign rd_to  = (state_q == READ) && !rd_ok && (rd_cnt_q >= RD_MAX);
  assign wr_end = (state_q == WRITE) && (wr_cnt_q >= WR_MAX);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unreachable encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = gnt_we ? WRITE : READ;
      READ:    if (rd_ok || rd_to) state_d = DONE;
      WRITE:   if (wr_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values: strobes follow the next state so every output comes from a flop.
  always_comb begin
    mem_cs_d  = (state_d == READ) || (state_d == WRITE);
    mem_we_d  = (state_d == WRITE);
    busy_d    = (state_d != IDLE);
    f_vld_d   = (state_d == DONE) && (port_q == PORT_FETCH);
    d_vld_d   = (state_d == DONE) && (port_q == PORT_DATA);
    err_d     = rd_to;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (gnt_any) begin
      mem_addr_d = gnt_data ? D_ADDR : F_ADDR;
      if (gnt_we) mem_din_d = D_WDATA;
    end
    if (rd_ok) begin
      if (port_q == PORT_FETCH) f_rdata_d = MEM_DOUT;
      else                      d_rdata_d = MEM_DOUT;
    end
  end

  // Bookkeeping next values: pointer, granted port and saturating cycle counters.
  always_comb begin
    ptr_d    = ptr_q;
    port_d   = port_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (gnt_any) begin
      ptr_d    = arb_ptr;
      port_d   = gnt_data ? PORT_DATA : PORT_FETCH;
      rd_cnt_d = RD_ONE;
      wr_cnt_d = WR_ONE;
    end else begin
      if ((state_q == READ) && (rd_cnt_q < RD_MAX))  rd_cnt_d = rd_cnt_q + RD_ONE;
      if ((state_q == WRITE) && (wr_cnt_q < WR_MAX)) wr_cnt_d = wr_cnt_q + WR_ONE;
    end
  end

  // Output and bookkeeping registers; reset clears everything and points priority at data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q      <= PORT_DATA;
      port_q     <= PORT_FETCH;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      f_vld_q    <= 1'b0;
      d_vld_q    <= 1'b0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      port_q     <= port_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      f_vld_q    <= f_vld_d;
      d_vld_q    <= d_vld_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign MEM_CS   = mem_cs_q;
  assign MEM_WE   = mem_we_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_DIN  = mem_din_q;
  assign F_VALID  = f_vld_q;
  assign D_VALID  = d_vld_q;
  assign F_RDATA  = f_rdata_q;
  assign D_RDATA  = d_rdata_q;
  assign ERR      = err_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM.
// Latency: n/a.
// Backpressure: RAM ready can be withheld to force read timeouts.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          F_REQ, D_REQ, D_WE;
  logic [AW-1:0] F_ADDR, D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          F_VALID, D_VALID, ERR, BUSY;
  logic [DW-1:0] F_RDATA, D_RDATA;
  logic          MEM_CS, MEM_WE, MEM_READY;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_DIN, MEM_DOUT;

  logic          rdy_en;
  logic          preload;
  logic [DW-1:0] ram [0:65535];

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .WRITE_CYCLES(1), .TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_VALID(F_VALID), .F_RDATA(F_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_VALID(D_VALID), .D_RDATA(D_RDATA),
    .ERR(ERR), .BUSY(BUSY),
    .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
    .MEM_DOUT(MEM_DOUT), .MEM_READY(MEM_READY)
  );

  always #5 CLK = ~CLK;

  // RAM model: asynchronous read, write on the clock edge while CS and WE are high.
  assign MEM_DOUT  = ram[MEM_ADDR];
  assign MEM_READY = rdy_en & MEM_CS & ~MEM_WE;

  always @(posedge CLK) begin
    if (preload) begin
      ram[16'h0002] <= 16'h2004;
      ram[16'h0010] <= 16'h0000;
      ram[16'h0020] <= 16'h1234;
    end else if (MEM_CS && MEM_WE) begin
      ram[MEM_ADDR] <= MEM_DIN;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait for the VALID pulse of one port; cyc counts cycles after the request cycle.
  task automatic wait_valid(input logic port, output int cyc, output logic err);
    cyc = -1;
    err = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if ((port == 1'b1) ? D_VALID : F_VALID) begin
        cyc = c;
        err = ERR;
        return;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic        e;
    int          vcnt;
    logic [6:0]  cs_seq;

    RST = 1'b1; F_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
    F_ADDR = '0; D_ADDR = '0; D_WDATA = '0;
    rdy_en = 1'b1; preload = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    preload = 1'b0;

    // Reset state
    chk("rst_strobes", {MEM_CS, MEM_WE, F_VALID, D_VALID, ERR, BUSY}, 0);
    chk("rst_addr_din", {MEM_ADDR, MEM_DIN}, 0);
    chk("rst_rdata", {F_RDATA, D_RDATA}, 0);
    RST = 1'b0;
    tick();

    // 1. Fetch read of RAM[2]
    F_ADDR = 16'h0002; F_REQ = 1'b1;
    tick();
    chk("t1_c1_cswe", {MEM_CS, MEM_WE}, 2'b10);
    chk("t1_c1_addr", MEM_ADDR, 16'h0002);
    chk("t1_c1_busy", BUSY, 1);
    F_ADDR = 16'h0055;
    tick();
    chk("t1_c2_cswe", {MEM_CS, MEM_WE}, 2'b10);
    chk("t1_c2_vld", {F_VALID, MEM_ADDR}, {1'b0, 16'h0002});
    tick();
    chk("t1_c3_vld", {F_VALID, D_VALID, ERR, MEM_CS}, 4'b1000);
    chk("t1_rdata", F_RDATA, 16'h2004);
    F_REQ = 1'b0;
    tick();
    chk("t1_c4_idle", {F_VALID, BUSY}, 2'b00);

    // 2. Store BEEF to 0x10, then load it back
    D_ADDR = 16'h0010; D_WDATA = 16'hBEEF; D_WE = 1'b1; D_REQ = 1'b1;
    tick();
    chk("t2_c1_cswe", {MEM_CS, MEM_WE}, 2'b11);
    chk("t2_c1_din", {MEM_ADDR, MEM_DIN}, {16'h0010, 16'hBEEF});
    D_WDATA = 16'h0000; D_WE = 1'b0;
    tick();
    chk("t2_c2_vld", {D_VALID, F_VALID, ERR, MEM_CS, MEM_WE}, 5'b10000);
    chk("t2_ram", ram[16'h0010], 16'hBEEF);
    D_REQ = 1'b0;
    tick();
    D_REQ = 1'b1;
    wait_valid(1'b1, cyc, e);
    D_REQ = 1'b0;
    chk("t2_ld_lat", cyc, 3);
    chk("t2_ld_data", {D_RDATA, F_RDATA}, {16'hBEEF, 16'h2004});
    chk("t2_ld_err", e, 0);
    tick();

    // 3. Contention from reset: grants alternate D,F,D,F
    RST = 1'b1;
    F_ADDR = 16'h0002; D_ADDR = 16'h0010; D_WE = 1'b0;
    F_REQ = 1'b1; D_REQ = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = 0;
      do begin
        tick();
        c++;
      end while (!(F_VALID || D_VALID) && c < 12);
      chk($sformatf("t3_lat%0d", k), c, (k == 0) ? 3 : 4);
      chk($sformatf("t3_port%0d", k), {D_VALID, F_VALID}, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    F_REQ = 1'b0; D_REQ = 1'b0;
    chk("t3_rdata", {F_RDATA, D_RDATA}, {16'h2004, 16'hBEEF});
    tick();

    // 4. Read timeout with RAM never ready, then a normal load
    rdy_en = 1'b0;
    D_ADDR = 16'h0020; D_REQ = 1'b1;
    wait_valid(1'b1, cyc, e);
    D_REQ = 1'b0;
    chk("t4_to_lat", cyc, 9);
    chk("t4_to_err", e, 1);
    chk("t4_to_keep", D_RDATA, 16'hBEEF);
    tick();
    chk("t4_err_pulse", {ERR, BUSY}, 2'b00);
    rdy_en = 1'b1;
    D_REQ = 1'b1;
    wait_valid(1'b1, cyc, e);
    D_REQ = 1'b0;
    chk("t4_ok_lat", cyc, 3);
    chk("t4_ok_err", e, 0);
    chk("t4_ok_data", D_RDATA, 16'h1234);
    tick();

    // 5. Reset in cycle 1 of a fetch
    F_ADDR = 16'h0002; F_REQ = 1'b1;
    tick();
    chk("t5_c1_cs", MEM_CS, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("t5_async_cs", {MEM_CS, BUSY}, 2'b00);
    F_REQ = 1'b0;
    vcnt = 0;
    repeat (3) begin
      tick();
      if (F_VALID || D_VALID) vcnt++;
    end
    chk("t5_no_vld", vcnt, 0);
    chk("t5_rdata_clr", {F_RDATA, D_RDATA}, 0);
    RST = 1'b0;
    D_ADDR = 16'h0010; F_REQ = 1'b1; D_REQ = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(F_VALID || D_VALID) && cyc < 12);
    chk("t5_first_port", {D_VALID, F_VALID}, 2'b10);
    F_REQ = 1'b0; D_REQ = 1'b0;
    tick();

    // 6. Held F_REQ: back-to-back fetches with a two-cycle deselect gap
    F_ADDR = 16'h0002; F_REQ = 1'b1;
    vcnt = 0;
    cs_seq = '0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      cs_seq[7-c] = MEM_CS;
      if (F_VALID) vcnt++;
      if (c == 7) begin
        chk("t6_c7_vld", F_VALID, 1);
        F_REQ = 1'b0;
      end
    end
    chk("t6_cs_seq", cs_seq, 7'b1100110);
    chk("t6_vcnt", vcnt, 2);
    tick();
    chk("t6_idle", {BUSY, MEM_CS}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
